// File: rtl/xform_seq_if.sv
// Port bundle for the xgen transform sequencer: the start/snapshot inputs, the bank
// mux drive and return, the transform stream, and the status outputs.
interface xform_seq_if #(
  parameter int WIDTH     = 32,
  parameter int NUM_LINKS = 7,
  parameter int LINK_W    = 3
);
  logic                       start_in;
  logic [NUM_LINKS*WIDTH-1:0] sinq_bus_in;
  logic [NUM_LINKS*WIDTH-1:0] cosq_bus_in;
  logic [LINK_W-1:0]          xgen_sel_out;
  logic [WIDTH-1:0]           xgen_sinq_out;
  logic [WIDTH-1:0]           xgen_cosq_out;
  logic [15*WIDTH-1:0]        xgen_res_in;
  logic                       xform_valid_out;
  logic                       xform_ready_in;
  logic [LINK_W-1:0]          xform_link_out;
  logic [15*WIDTH-1:0]        xform_data_out;
  logic                       busy_out;
  logic                       done_out;

  modport master (
    input  start_in, sinq_bus_in, cosq_bus_in, xgen_res_in, xform_ready_in,
    output xgen_sel_out, xgen_sinq_out, xgen_cosq_out,
           xform_valid_out, xform_link_out, xform_data_out, busy_out, done_out
  );

  modport slave (
    output start_in, sinq_bus_in, cosq_bus_in, xgen_res_in, xform_ready_in,
    input  xgen_sel_out, xgen_sinq_out, xgen_cosq_out,
           xform_valid_out, xform_link_out, xform_data_out, busy_out, done_out
  );
endinterface

// File: rtl/xform_seq_ctrl.sv
// Steps the xgen bank through links 1..NUM_LINKS from a start-time snapshot of
// sin/cos and streams each registered 15-entry transform over valid/ready.
module xform_seq_ctrl #(
  parameter int WIDTH        = 32,
  parameter int DECIMAL_BITS = 16,
  parameter int NUM_LINKS    = 7,
  parameter int LINK_W       = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  xform_seq_if.master  bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [LINK_W-1:0] LAST = LINK_W'(NUM_LINKS);

  // Fraction bits only matter to the bank; here they just have to fit the word.
  if (DECIMAL_BITS >= WIDTH || NUM_LINKS < 1 || NUM_LINKS > (2**LINK_W) - 1) begin : g_bad_param
    $error("xform_seq_ctrl: illegal DECIMAL_BITS/NUM_LINKS/LINK_W combination");
  end

  logic [1:0]                           state;
  logic [LINK_W-1:0]                    cnt;
  logic [LINK_W-1:0]                    idx;
  logic [NUM_LINKS-1:0][WIDTH-1:0]      sin_snap, cos_snap;
  logic                                 busy_r, done_r, valid_r;
  logic [LINK_W-1:0]                    link_r;
  logic [15*WIDTH-1:0]                  data_r;
  logic                                 issue, load;

  assign issue = (state == S_ISSUE);
  assign load  = issue && (!valid_r || bus.xform_ready_in);
  assign idx   = cnt - LINK_W'(1);

  // Bank inputs only move when cnt moves, so a stalled link keeps a stable result.
  assign bus.xgen_sel_out  = issue ? cnt : '0;
  assign bus.xgen_sinq_out = issue ? sin_snap[idx] : '0;
  assign bus.xgen_cosq_out = issue ? cos_snap[idx] : '0;

  assign bus.xform_valid_out = valid_r;
  assign bus.xform_link_out  = link_r;
  assign bus.xform_data_out  = data_r;
  assign bus.done_out        = done_r;
  // Busy rises in the accepting cycle so back-to-back passes only drop it for DONE.
  assign bus.busy_out        = busy_r | (state == S_IDLE && bus.start_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      sin_snap <= '0;
      cos_snap <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      valid_r  <= 1'b0;
      link_r   <= '0;
      data_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_in) begin
            sin_snap <= bus.sinq_bus_in;
            cos_snap <= bus.cosq_bus_in;
            cnt      <= LINK_W'(1);
            busy_r   <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (load) begin
            data_r  <= bus.xgen_res_in;
            link_r  <= cnt;
            valid_r <= 1'b1;
            if (cnt == LAST) state <= S_DRAIN;
            else             cnt   <= cnt + LINK_W'(1);
          end
        end
        S_DRAIN: begin
          if (valid_r && bus.xform_ready_in) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xform_seq_ctrl.sv
// Bench for xform_seq_ctrl: a toy xgen bank plus a per-pass scoreboard of the
// expected link sequence built from the buses seen at start.
module tb_xform_seq_ctrl;
  localparam int WIDTH = 32;
  localparam int NL    = 7;
  localparam int LW    = 3;
  localparam int DW    = 15 * WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  xform_seq_if #(.WIDTH(WIDTH), .NUM_LINKS(NL), .LINK_W(LW)) bus ();

  xform_seq_ctrl #(.WIDTH(WIDTH), .DECIMAL_BITS(16), .NUM_LINKS(NL), .LINK_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Arbitrary but link-distinct bank function of (sel, sin, cos).
  function automatic logic [DW-1:0] bank(input logic [LW-1:0] sel,
                                          input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < 15; i++)
      r[i*WIDTH +: WIDTH] = s * WIDTH'(i + 1) + (c ^ WIDTH'(i * 7)) + (WIDTH'(sel) << 24);
    return r;
  endfunction

  always_comb bus.xgen_res_in = bank(bus.xgen_sel_out, bus.xgen_sinq_out, bus.xgen_cosq_out);

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_buses(input int mode);
    logic [NL*WIDTH-1:0] sb, cb;
    for (int k = 1; k <= NL; k++) begin
      sb[(k-1)*WIDTH +: WIDTH] = (mode == 0) ? WIDTH'(k * 65536)  : WIDTH'($urandom);
      cb[(k-1)*WIDTH +: WIDTH] = (mode == 0) ? WIDTH'(-k * 65536) : WIDTH'($urandom);
    end
    bus.sinq_bus_in = sb;
    bus.cosq_bus_in = cb;
  endtask

  // Starts at a negedge in IDLE; returns at the negedge after the done cycle.
  task automatic run_pass(input int mode, input int stall_lo, input int stall_hi,
                          input int last_stall, input int exp_done,
                          input bit mid_change, input bit hold_start);
    logic [WIDTH-1:0] s_snap [1:NL];
    logic [WIDTH-1:0] c_snap [1:NL];
    int               exp_q [$];
    int               last_x, held, k;
    bit               done_seen, pv_stall, r, all_ready;
    logic [LW-1:0]    pl;
    logic [DW-1:0]    pd;
    all_ready = (mode != 2) && (stall_lo > stall_hi) && (last_stall == 0);
    set_buses(mode);
    for (int i = 1; i <= NL; i++) begin
      s_snap[i] = bus.sinq_bus_in[(i-1)*WIDTH +: WIDTH];
      c_snap[i] = bus.cosq_bus_in[(i-1)*WIDTH +: WIDTH];
      exp_q.push_back(i);
    end
    bus.start_in = 1'b1;
    bus.xform_ready_in = 1'b1;
    #1 chk("busy_accept", bus.busy_out, 1);
    @(negedge clk);
    bus.start_in = hold_start;
    last_x = 0; held = 0; done_seen = 0; pv_stall = 0; pl = '0; pd = '0;
    for (int c = 1; c <= 300 && !done_seen; c++) begin
      if (pv_stall) begin
        chk("hold_link", bus.xform_link_out, pl);
        chk("hold_data", bus.xform_data_out, pd);
      end
      if (bus.done_out) begin
        done_seen = 1;
        chk("done_all_sent", exp_q.size(), 0);
        chk("done_after_last", c, last_x + 1);
        if (exp_done != 0) chk("done_cycle", c, exp_done);
        chk("busy_in_done", bus.busy_out, 0);
        chk("valid_in_done", bus.xform_valid_out, 0);
      end else begin
        chk("busy_mid", bus.busy_out, 1);
      end
      if (stall_lo == 3 && c == 3) begin
        chk("bp_sel", bus.xgen_sel_out, 3);
        chk("bp_link", bus.xform_link_out, 2);
      end
      r = 1'b1;
      if (c >= stall_lo && c <= stall_hi) r = 1'b0;
      if (mode == 2) r = ($urandom_range(0, 2) != 0);
      if (last_stall > 0 && bus.xform_valid_out && bus.xform_link_out == LW'(NL) && held < last_stall) begin
        r = 1'b0;
        held++;
        chk("drain_sel", bus.xgen_sel_out, 0);
      end
      if (mid_change && c == 3) begin
        set_buses(1);
        bus.start_in = 1'b1;
      end else begin
        bus.start_in = hold_start;
      end
      bus.xform_ready_in = r;
      if (bus.xform_valid_out && r) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", bus.xform_link_out, 0);
        end else begin
          k = exp_q.pop_front();
          chk("link", bus.xform_link_out, k);
          chk("data", bus.xform_data_out, bank(LW'(k), s_snap[k], c_snap[k]));
          if (all_ready) chk("xfer_cycle", c, k + 1);
        end
        last_x = c;
      end
      pv_stall = bus.xform_valid_out && !r;
      pl = bus.xform_link_out;
      pd = bus.xform_data_out;
      @(negedge clk);
    end
    chk("pass_finished", done_seen, 1);
    chk("done_one_cycle", bus.done_out, 0);
    chk("valid_after", bus.xform_valid_out, 0);
    chk("busy_after", bus.busy_out, hold_start);
  endtask

  initial begin
    bus.start_in = 1'b0;
    bus.xform_ready_in = 1'b0;
    bus.sinq_bus_in = '0;
    bus.cosq_bus_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", bus.xform_valid_out, 0);
    chk("rst_busy", bus.busy_out, 0);
    chk("rst_done", bus.done_out, 0);
    chk("rst_sel", bus.xgen_sel_out, 0);
    chk("rst_data", bus.xform_data_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_pass(0, 99, 0, 0, 9, 0, 0);    // patterned stream, ready high
    run_pass(0, 3, 5, 0, 12, 0, 0);    // backpressure cycles 3..5
    run_pass(1, 99, 0, 0, 9, 1, 0);    // bus change + start pulse mid-pass
    run_pass(1, 99, 0, 4, 13, 0, 0);   // last-beat stall in DRAIN
    run_pass(1, 99, 0, 0, 9, 0, 1);    // back-to-back, start held
    run_pass(1, 99, 0, 0, 9, 0, 0);
    repeat (6) run_pass(2, 99, 0, 0, 0, 0, 0);

    // Abort mid-ISSUE with an asynchronous reset.
    set_buses(1);
    bus.start_in = 1'b1;
    bus.xform_ready_in = 1'b1;
    @(negedge clk);
    bus.start_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_sel", bus.xgen_sel_out, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", bus.xform_valid_out, 0);
    chk("abort_busy", bus.busy_out, 0);
    chk("abort_sel", bus.xgen_sel_out, 0);
    chk("abort_data", bus.xform_data_out, 0);
    chk("abort_done", bus.done_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_valid", bus.xform_valid_out, 0);
    chk("idle_busy", bus.busy_out, 0);
    run_pass(2, 99, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
